// File: rtl/opti_iir_pkg.sv
// Shared widths, default coefficient set and round/saturate helpers for the IIR cascade.
package opti_iir_pkg;

  localparam int DATA_W    = 24;
  localparam int COEF_W    = 24;
  localparam int COEF_FRAC = 22;
  localparam int ACC_W     = 51;
  localparam int PROD_W    = DATA_W + COEF_W;
  localparam int SOS_W     = 5 * COEF_W;
  localparam int SHIFT_W   = ACC_W - COEF_FRAC;

  // One section word is {b0,b1,b2,a1,a2}; b0 = 1.0 in Q2.22 gives a pass-through section.
  localparam logic [SOS_W-1:0] SOS_IDENTITY = {24'h400000, 24'h000000, 24'h000000, 24'h000000, 24'h000000};

  localparam logic signed [ACC_W-1:0]   ROUND_HALF = 51'sd2097152;
  localparam logic signed [SHIFT_W-1:0] SAT_MAX    = 29'sd8388607;
  localparam logic signed [SHIFT_W-1:0] SAT_MIN    = -29'sd8388608;

  // Sign-extend a 48-bit product into the accumulator width.
  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return $signed({{(ACC_W-PROD_W){p[PROD_W-1]}}, p});
  endfunction

  // Round half-up at bit COEF_FRAC, then clamp to the signed 24-bit sample range.
  function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0]   w_rnd;
    logic signed [SHIFT_W-1:0] w_shf;
    logic signed [DATA_W-1:0]  w_res;
    w_rnd = acc + ROUND_HALF;
    w_shf = w_rnd[ACC_W-1:COEF_FRAC];
    if (w_shf > SAT_MAX) begin
      w_res = 24'sh7FFFFF;
    end else if (w_shf < SAT_MIN) begin
      w_res = 24'sh800000;
    end else begin
      w_res = w_shf[DATA_W-1:0];
    end
    return w_res;
  endfunction

endpackage

// File: rtl/opti_iir_top_sos.sv
// One Direct Form I biquad: input reg -> MAC/feedback reg -> output reg.
// The feedback terms come from history registers written in the same cycle as the
// MAC result, so the recursion closes in one clock and a sample per clock is accepted.
module opti_sos
  import opti_iir_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clr,
  input  logic [SOS_W-1:0]         i_coefs,
  input  logic signed [DATA_W-1:0] i_data,
  input  logic                     i_valid,
  output logic signed [DATA_W-1:0] o_data,
  output logic                     o_valid
);

  logic signed [COEF_W-1:0] w_b0, w_b1, w_b2, w_a1, w_a2;
  logic signed [DATA_W-1:0] r_x, r_x1, r_x2, r_y1, r_y2, r_y, r_out;
  logic                     r_v1, r_v2, r_v3;
  logic signed [PROD_W-1:0] w_p0, w_p1, w_p2, w_p3, w_p4;
  logic signed [ACC_W-1:0]  w_acc;
  logic signed [DATA_W-1:0] w_y;
  logic                     w_clear;

  assign w_b0 = i_coefs[5*COEF_W-1 -: COEF_W];
  assign w_b1 = i_coefs[4*COEF_W-1 -: COEF_W];
  assign w_b2 = i_coefs[3*COEF_W-1 -: COEF_W];
  assign w_a1 = i_coefs[2*COEF_W-1 -: COEF_W];
  assign w_a2 = i_coefs[COEF_W-1:0];

  assign w_p0 = w_b0 * r_x;
  assign w_p1 = w_b1 * r_x1;
  assign w_p2 = w_b2 * r_x2;
  assign w_p3 = w_a1 * r_y1;
  assign w_p4 = w_a2 * r_y2;
  assign w_acc = sext_prod(w_p0) + sext_prod(w_p1) + sext_prod(w_p2)
               - sext_prod(w_p3) - sext_prod(w_p4);
  assign w_y = round_sat(w_acc);

  assign w_clear = i_rst_n | i_clr;

  // Three pipeline stages; history only advances when a valid sample reaches the MAC.
  always_ff @(posedge i_clk) begin
    if (w_clear) begin
      r_x   <= '0;
      r_x1  <= '0;
      r_x2  <= '0;
      r_y1  <= '0;
      r_y2  <= '0;
      r_y   <= '0;
      r_out <= '0;
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_v3  <= 1'b0;
    end else begin
      if (i_valid) r_x <= i_data;
      r_v1 <= i_valid;
      if (r_v1) begin
        r_x1 <= r_x;
        r_x2 <= r_x1;
        r_y1 <= w_y;
        r_y2 <= r_y1;
        r_y  <= w_y;
      end
      r_v2 <= r_v1;
      if (r_v2) r_out <= r_y;
      r_v3 <= r_v2;
    end
  end

  assign o_data  = r_out;
  assign o_valid = r_v3;

endmodule

// File: rtl/opti_iir_top.sv
// Cascade of NUM_SOS biquads with frame address, settle flag and frame-done pulse.
module opti_iir_top
  import opti_iir_pkg::*;
#(
  parameter int                         NUM_SOS    = 4,
  parameter int                         FRAME_LEN  = 2048,
  parameter int                         STABLE_CNT = 64,
  parameter logic [NUM_SOS*SOS_W-1:0]   COEFS      = {NUM_SOS{SOS_IDENTITY}},
  localparam int                        ADDR_W     = $clog2(FRAME_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  output logic [ADDR_W-1:0] addr,
  output logic              stable_out,
  output logic              filter_done
);

  localparam int CNT_W = $clog2(STABLE_CNT + 1);

  logic [DATA_W-1:0] w_d [NUM_SOS+1];
  logic              w_v [NUM_SOS+1];
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_out_v;

  assign w_d[0] = data_in;
  assign w_v[0] = data_in_valid;

  for (genvar g = 0; g < NUM_SOS; g++) begin : g_sos
    opti_sos u_sos (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_clr   (start),
      .i_coefs (COEFS[g*SOS_W +: SOS_W]),
      .i_data  (w_d[g]),
      .i_valid (w_v[g]),
      .o_data  (w_d[g+1]),
      .o_valid (w_v[g+1])
    );
  end

  assign w_out_v = w_v[NUM_SOS];

  // Output index (wrapping per frame) and saturating count of outputs since start.
  always_ff @(posedge clk) begin
    if (rst_n || start) begin
      r_addr <= '0;
      r_cnt  <= '0;
    end else if (w_out_v) begin
      if (r_addr == ADDR_W'(FRAME_LEN - 1)) r_addr <= '0;
      else                                  r_addr <= r_addr + 1'b1;
      if (r_cnt != CNT_W'(STABLE_CNT)) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign data_out       = w_d[NUM_SOS];
  assign data_out_valid = w_out_v;
  assign addr           = r_addr;
  assign filter_done    = w_out_v && (r_addr == ADDR_W'(FRAME_LEN - 1));
  assign stable_out     = (r_cnt == CNT_W'(STABLE_CNT)) ||
                          (w_out_v && (r_cnt == CNT_W'(STABLE_CNT - 1)));

endmodule

// File: tb/tb_opti_iir_top.sv
// Scoreboard bench: three filter instances (identity x4, single decaying pole, single gain ~2).
module tb_opti_iir_top;
  import opti_iir_pkg::*;

  typedef struct {
    logic [23:0] d;
    logic [10:0] a;
    int          c;
    logic        done;
    logic        stb;
  } exp_t;

  localparam logic [119:0] C_DECAY = {24'h400000, 24'h000000, 24'h000000, 24'hE00000, 24'h000000};
  localparam logic [119:0] C_GAIN2 = {24'h7FFFFF, 24'h000000, 24'h000000, 24'h000000, 24'h000000};

  logic        clk = 1'b0;
  logic        rst;
  logic        st   [3];
  logic [23:0] din  [3];
  logic        vin  [3];
  logic [23:0] dout [3];
  logic        vout [3];
  logic [10:0] aout [3];
  logic        stb  [3];
  logic        done [3];

  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          lat [3] = '{12, 3, 3};
  logic [10:0] acnt [3];
  int          ocnt [3];
  logic [23:0] last [3];
  exp_t        q0[$], q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  opti_iir_top dut0 (
    .clk(clk), .rst_n(rst), .start(st[0]), .data_in(din[0]), .data_in_valid(vin[0]),
    .data_out(dout[0]), .data_out_valid(vout[0]), .addr(aout[0]), .stable_out(stb[0]),
    .filter_done(done[0]));

  opti_iir_top #(.NUM_SOS(1), .COEFS(C_DECAY)) dut1 (
    .clk(clk), .rst_n(rst), .start(st[1]), .data_in(din[1]), .data_in_valid(vin[1]),
    .data_out(dout[1]), .data_out_valid(vout[1]), .addr(aout[1]), .stable_out(stb[1]),
    .filter_done(done[1]));

  opti_iir_top #(.NUM_SOS(1), .COEFS(C_GAIN2)) dut2 (
    .clk(clk), .rst_n(rst), .start(st[2]), .data_in(din[2]), .data_in_valid(vin[2]),
    .data_out(dout[2]), .data_out_valid(vout[2]), .addr(aout[2]), .stable_out(stb[2]),
    .filter_done(done[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic clear_dut(input int d);
    acnt[d] = 11'd0;
    ocnt[d] = 0;
    last[d] = 24'h000000;
    case (d)
      0: q0.delete();
      1: q1.delete();
      default: q2.delete();
    endcase
  endtask

  task automatic push(input int d, input logic [23:0] v);
    exp_t e;
    e.d    = v;
    e.a    = acnt[d];
    e.c    = cyc + lat[d];
    e.done = (acnt[d] == 11'd2047);
    e.stb  = (ocnt[d] >= 63);
    acnt[d] = acnt[d] + 11'd1;
    ocnt[d]++;
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic check_dut(input int d);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (vout[d] === 1'b1) begin
      case (d)
        0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
      endcase
      chk($sformatf("dut%0d_expected_output", d), 32'(have), 32'd1);
      if (have) begin
        chk($sformatf("dut%0d_data", d), 32'(dout[d]), 32'(e.d));
        chk($sformatf("dut%0d_addr", d), 32'(aout[d]), 32'(e.a));
        chk($sformatf("dut%0d_latency_cycle", d), 32'(cyc), 32'(e.c));
        chk($sformatf("dut%0d_done", d), 32'(done[d]), 32'(e.done));
        chk($sformatf("dut%0d_stable", d), 32'(stb[d]), 32'(e.stb));
      end
      last[d] = dout[d];
    end else begin
      chk($sformatf("dut%0d_hold", d), 32'(dout[d]), 32'(last[d]));
      chk($sformatf("dut%0d_done_idle", d), 32'(done[d]), 32'd0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int d = 0; d < 3; d++) check_dut(d);
  endtask

  task automatic drive(input int d, input logic v, input logic [23:0] x, input logic [23:0] ev);
    vin[d] = v;
    din[d] = x;
    if (v) push(d, ev);
    tick();
  endtask

  task automatic do_start(input int d);
    st[d] = 1'b1;
    clear_dut(d);
    tick();
    st[d] = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int d = 0; d < 3; d++) vin[d] = 1'b0;
    repeat (n) tick();
  endtask

  task automatic run_ramp();
    for (int i = 0; i < 2048; i++) drive(0, 1'b1, 24'(i), 24'(i));
    drain(16);
    chk("ramp_queue_empty", 32'(q0.size()), 32'd0);
    chk("ramp_addr_wrapped", 32'(aout[0]), 32'd0);
    chk("ramp_stable_held", 32'(stb[0]), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      st[d] = 1'b0; vin[d] = 1'b0; din[d] = 24'h000000;
      clear_dut(d);
    end
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_data%0d", d), 32'(dout[d]), 32'd0);
      chk($sformatf("reset_valid%0d", d), 32'(vout[d]), 32'd0);
      chk($sformatf("reset_addr%0d", d), 32'(aout[d]), 32'd0);
      chk($sformatf("reset_stable%0d", d), 32'(stb[d]), 32'd0);
    end
    rst = 1'b0;

    // Identity cascade: ramp of a whole frame, done on the last sample.
    run_ramp();

    // Single pole at 0.5: impulse halves exactly.
    for (int k = 0; k < 12; k++)
      drive(1, 1'b1, (k == 0) ? 24'h100000 : 24'h000000, 24'h100000 >> k);
    drain(8);
    chk("decay_queue_empty", 32'(q1.size()), 32'd0);

    // Same impulse with bubbles carrying junk data.
    do_start(1);
    for (int k = 0; k < 12; k++) begin
      drive(1, 1'b1, (k == 0) ? 24'h100000 : 24'h000000, 24'h100000 >> k);
      drive(1, 1'b0, 24'h5A5A5A, 24'h000000);
    end
    drain(8);
    chk("bubble_queue_empty", 32'(q1.size()), 32'd0);

    // Gain ~2: clamp at both ends, exact rounding in range.
    drive(2, 1'b1, 24'h600000, 24'h7FFFFF);
    drive(2, 1'b1, 24'hA00000, 24'h800000);
    drive(2, 1'b1, 24'h100000, 24'h200000);
    drive(2, 1'b1, 24'hF00000, 24'hE00000);
    drive(2, 1'b1, 24'h7FFFFF, 24'h7FFFFF);
    drive(2, 1'b1, 24'h800000, 24'h800000);
    drain(8);
    chk("sat_queue_empty", 32'(q2.size()), 32'd0);

    // Settle flag, then start mid-frame with a sample in the start cycle.
    do_start(0);
    for (int i = 0; i < 80; i++) drive(0, 1'b1, 24'(i * 3), 24'(i * 3));
    st[0] = 1'b1; vin[0] = 1'b1; din[0] = 24'h777777;
    clear_dut(0);
    tick();
    st[0] = 1'b0;
    drain(16);
    chk("start_addr_zero", 32'(aout[0]), 32'd0);
    chk("start_stable_zero", 32'(stb[0]), 32'd0);
    for (int i = 0; i < 5; i++) drive(0, 1'b1, 24'(256 + i), 24'(256 + i));
    drain(16);
    chk("post_start_queue_empty", 32'(q0.size()), 32'd0);
    chk("post_start_addr", 32'(aout[0]), 32'd5);

    // Reset mid-stream, then the full ramp again.
    for (int i = 0; i < 30; i++) drive(0, 1'b1, 24'(i + 9), 24'(i + 9));
    rst = 1'b1; vin[0] = 1'b1; din[0] = 24'h123456;
    for (int d = 0; d < 3; d++) clear_dut(d);
    tick();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("midrst_data%0d", d), 32'(dout[d]), 32'd0);
      chk($sformatf("midrst_valid%0d", d), 32'(vout[d]), 32'd0);
      chk($sformatf("midrst_addr%0d", d), 32'(aout[d]), 32'd0);
      chk($sformatf("midrst_stable%0d", d), 32'(stb[d]), 32'd0);
      chk($sformatf("midrst_done%0d", d), 32'(done[d]), 32'd0);
    end
    rst = 1'b0;
    vin[0] = 1'b0;
    drain(16);
    run_ramp();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
